block_transfer_sequencer: RTL and testbench
===========================================

BLOCK_TRANSFER_SEQUENCER -- requirements
Module: block_transfer_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: start  in  1  begin a block transfer; sampled only in IDLE.
REQ-004 SHALL have: reg_list  in  16  register mask; bit i set means register i is transferred.
REQ-005 SHALL have: base_addr  in  32  base register value.
REQ-006 SHALL have: up  in  1  1 means increment, 0 means decrement.
REQ-007 SHALL have: pre  in  1  1 means adjust before access, 0 means after.
REQ-008 SHALL have: xfer_ready  in  1  consumer accepts the current transfer.
REQ-009 SHALL have: xfer_valid  out  1  reg_address/mem_addr hold a valid transfer.
REQ-010 SHALL have: reg_address  out  4  register of the current transfer.
REQ-011 SHALL have: mem_addr  out  32  word address of the current transfer.
REQ-012 SHALL have: last  out  1  current transfer is the final one.
REQ-013 SHALL have: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have: reg_count  out  5  popcount of the latched mask, 0..16.
REQ-016 SHALL have: wb_addr  out  32  base writeback value; valid while done=1.

Function
REQ-017 SHALL implement states IDLE, XFER and DONE.
REQ-018 IDLE with start=1 SHALL, on that edge:
- latch reg_list into a pending mask;
- latch reg_count = popcount(reg_list);
- latch the start address;
- go to XFER, or to DONE if reg_count=0.
REQ-019 Start address (n=reg_count) SHALL be:
- up&pre: base+4;
- up&!pre: base;
- !up&pre: base-4n;
- !up&!pre: base-4n+4.
REQ-020 Transfers SHALL always proceed lowest-numbered register first, at ascending addresses regardless of up.
REQ-021 In XFER, xfer_valid SHALL be 1, reg_address SHALL be the lowest set bit of the pending mask, and last SHALL be 1 when exactly one bit remains.
REQ-022 In XFER with xfer_ready=1, on that edge the block SHALL clear the lowest pending bit, add 4 to mem_addr, and go to DONE if last=1.
REQ-023 In XFER with xfer_ready=0, all outputs SHALL hold stable with no state change.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 base_addr, up, pre and reg_list changes after the start edge SHALL have no effect on the transfer in progress.
REQ-027 Address arithmetic SHALL be modulo 2^32, with wrap-around permitted.
REQ-028 A back-to-back start in the cycle after done SHALL be accepted.
REQ-029 Latency from start to the first xfer_valid SHALL be 1 cycle.
REQ-030 Total cycles for n>0 with xfer_ready held at 1 SHALL be 1 + n + 1, counting the start edge, n transfers, and DONE.

Reset
REQ-031 While reset=1, the block SHALL be in state IDLE with all outputs 0: xfer_valid, reg_address, mem_addr, last, busy, done, reg_count, wb_addr.
REQ-032 Reset asserted mid-transfer SHALL abort immediately, with no done pulse and the pending mask cleared.
REQ-033 The first start SHALL be honoured on the first rising edge after reset deasserts.

Configuration
REQ-034 Macro BLOCK_TRANSFER_WRITEBACK_EN SHALL control writeback:
- defined: wb_addr is registered in DONE as base+4n (up=1) or base-4n (up=0), using the latched base;
- undefined: wb_addr is driven constant 0 and no writeback adder is built.

Verification
REQ-035 The bench SHALL cover the following scenarios:
- V1 (IA): base=0x100, up=1, pre=0, list=0x0013, ready=1 -> (r0,0x100), (r1,0x104), (r4,0x108); last on r4; done next cycle; wb=0x10C (macro on).
- V2 (DB): base=0x200, up=0, pre=1, list=0x8001 -> (r0,0x1F8), (r15,0x1FC); wb=0x1F8; reg_count=2.
- V3 (empty list): list=0x0000, start -> no xfer_valid; done one cycle after start; wb=base; reg_count=0.
- V4 (backpressure): list=0x0006, ready low 3 cycles at r1 -> r1/mem_addr stable for 4 cycles, then r2; start pulses mid-transfer are ignored.
- V5 (reset mid-transfer): list=0xFFFF, reset asserted after 5th accept -> all outputs 0 asynchronously, no done; a new start after release restarts from r0.
- V6 (full and wrap): list=0xFFFF, base=0xFFFFFFF8, IA -> 16 transfers with mem_addr wrapping past 0 to 0x00000034; wb=0x00000038; macro off -> wb=0.

Source files
------------

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: walks a 16-bit register mask lowest-first, emitting
// one (register, word address) transfer per accepted handshake.
// Optional writeback of the updated base address: define BLOCK_TRANSFER_WRITEBACK_EN.
module block_transfer_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  input  logic        up,
  input  logic        pre,
  input  logic        xfer_ready,
  output logic        xfer_valid,
  output logic [3:0]  reg_address,
  output logic [31:0] mem_addr,
  output logic        last,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_count,
  output logic [31:0] wb_addr
);

  localparam int unsigned MASK_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic [MASK_W-1:0]   pending_q, pending_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [CNT_W-1:0]    reg_count_d;
  logic [CNT_W-1:0]    list_count;
  logic [ADDR_W-1:0]   list_bytes;
  logic                xfer_valid_d, last_d, busy_d, done_d;
  logic [IDX_W-1:0]    reg_address_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(MASK_W); i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MASK_W-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(MASK_W) - 1; i >= 0; i--) if (m[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  function automatic logic one_left(input logic [MASK_W-1:0] m);
    return (m != '0) && ((m & (m - MASK_W'(1))) == '0);
  endfunction

  // Next-state, pending mask, address walk and registered output values.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    mem_addr_d  = mem_addr;
    reg_count_d = reg_count;
    list_count  = popcount(reg_list);
    list_bytes  = ADDR_W'(list_count) << 2;

    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d   = reg_list;
          reg_count_d = list_count;
          // Lowest address of the block; transfers always ascend from here.
          case ({up, pre})
            2'b11:   mem_addr_d = base_addr + ADDR_W'(4);
            2'b10:   mem_addr_d = base_addr;
            2'b01:   mem_addr_d = base_addr - list_bytes;
            default: mem_addr_d = base_addr - list_bytes + ADDR_W'(4);
          endcase
          state_d = (list_count == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (xfer_ready) begin
          pending_d  = pending_q & (pending_q - MASK_W'(1));
          mem_addr_d = mem_addr + ADDR_W'(4);
          if (one_left(pending_q)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    xfer_valid_d  = (state_d == XFER);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    reg_address_d = lowest_set(pending_d);
    last_d        = (state_d == XFER) && one_left(pending_d);
  end

  // State and output registers; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mem_addr    <= '0;
      reg_count   <= '0;
      xfer_valid  <= 1'b0;
      reg_address <= '0;
      last        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mem_addr    <= mem_addr_d;
      reg_count   <= reg_count_d;
      xfer_valid  <= xfer_valid_d;
      reg_address <= reg_address_d;
      last        <= last_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef BLOCK_TRANSFER_WRITEBACK_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic              up_q, up_d;
  logic [ADDR_W-1:0] wb_d;
  logic [ADDR_W-1:0] wb_bytes;

  // Latch base/direction at start; compute writeback as DONE is entered.
  always_comb begin
    base_d   = base_q;
    up_d     = up_q;
    wb_d     = wb_addr;
    if (state_q == IDLE && start) begin
      base_d = base_addr;
      up_d   = up;
    end
    wb_bytes = ADDR_W'(reg_count_d) << 2;
    if (state_d == DONE && state_q != DONE)
      wb_d = up_d ? (base_d + wb_bytes) : (base_d - wb_bytes);
  end

  // Writeback registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      up_q    <= 1'b0;
      wb_addr <= '0;
    end else begin
      base_q  <= base_d;
      up_q    <= up_d;
      wb_addr <= wb_d;
    end
  end
`else
  assign wb_addr = '0;
`endif

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Scoreboard bench for block_transfer_sequencer: stimulus pushes expected
// transfers/completions; a negedge monitor pops and compares.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        up, pre, xfer_ready;
  logic        xfer_valid;
  logic [3:0]  reg_address;
  logic [31:0] mem_addr;
  logic        last, busy, done;
  logic [4:0]  reg_count;
  logic [31:0] wb_addr;

  int checks = 0;
  int passed = 0;

  typedef struct { logic [3:0] r; logic [31:0] a; logic l; } xfer_t;
  typedef struct { logic [31:0] wb; logic [4:0] n; } done_t;
  xfer_t xq[$];
  done_t dq[$];

  block_transfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .up(up), .pre(pre), .xfer_ready(xfer_ready),
    .xfer_valid(xfer_valid), .reg_address(reg_address), .mem_addr(mem_addr),
    .last(last), .busy(busy), .done(done), .reg_count(reg_count), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] wb_exp(input logic [31:0] v);
`ifdef BLOCK_TRANSFER_WRITEBACK_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_x(input logic [3:0] r, input logic [31:0] a, input logic l);
    xfer_t e;
    e.r = r; e.a = a; e.l = l;
    xq.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] wb, input logic [4:0] n);
    done_t e;
    e.wb = wb_exp(wb); e.n = n;
    dq.push_back(e);
  endtask

  // Issue start for one edge, then scramble the operands to prove they were latched.
  task automatic start_blk(input logic [15:0] list, input logic [31:0] base,
                           input logic u, input logic p);
    reg_list = list; base_addr = base; up = u; pre = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reg_list = 16'hA5A5; base_addr = 32'hDEADBEEF; up = ~u; pre = ~p;
  endtask

  // Count edges until the block returns to idle, bounded.
  task automatic wait_idle(input int exp_edges, input string name);
    int cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 32'(cnt), 32'(exp_edges));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(xfer_valid), 32'h0);
    check({tag, "_reg"},   32'(reg_address), 32'h0);
    check({tag, "_addr"},  mem_addr, 32'h0);
    check({tag, "_last"},  32'(last), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_count"}, 32'(reg_count), 32'h0);
    check({tag, "_wb"},    wb_addr, 32'h0);
  endtask

  // Monitor: compare every accepted transfer and every completion pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (xfer_valid && xfer_ready) begin
        if (xq.size() == 0) check("xfer_unexpected", 32'h1, 32'h0);
        else begin
          xfer_t e;
          e = xq.pop_front();
          check("xfer_reg",  32'(reg_address), 32'(e.r));
          check("xfer_addr", mem_addr, e.a);
          check("xfer_last", 32'(last), 32'(e.l));
        end
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", 32'h1, 32'h0);
        else begin
          done_t d;
          d = dq.pop_front();
          check("done_wb",    wb_addr, d.wb);
          check("done_count", 32'(reg_count), 32'(d.n));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0;
    up = 1'b0; pre = 1'b0; xfer_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_all_zero("rst");
    reset = 1'b0;

    // V1: increment-after, first start on first edge after reset release
    xfer_ready = 1'b1;
    push_x(4'd0, 32'h100, 1'b0);
    push_x(4'd1, 32'h104, 1'b0);
    push_x(4'd4, 32'h108, 1'b1);
    push_d(32'h10C, 5'd3);
    start_blk(16'h0013, 32'h100, 1'b1, 1'b0);
    check("v1_latency", 32'(xfer_valid), 32'h1);
    check("v1_count", 32'(reg_count), 32'd3);
    wait_idle(4, "v1_cycles");

    // V2: decrement-before, started back-to-back after V1's done
    push_x(4'd0,  32'h1F8, 1'b0);
    push_x(4'd15, 32'h1FC, 1'b1);
    push_d(32'h1F8, 5'd2);
    start_blk(16'h8001, 32'h200, 1'b0, 1'b1);
    wait_idle(3, "v2_cycles");

    // V3: empty list goes straight to DONE
    push_d(32'h300, 5'd0);
    start_blk(16'h0000, 32'h300, 1'b1, 1'b1);
    check("v3_no_valid", 32'(xfer_valid), 32'h0);
    check("v3_done", 32'(done), 32'h1);
    wait_idle(1, "v3_cycles");

    // V4: backpressure on r1 with an ignored mid-transfer start
    xfer_ready = 1'b0;
    push_x(4'd1, 32'h1004, 1'b0);
    push_x(4'd2, 32'h1008, 1'b1);
    push_d(32'h1008, 5'd2);
    start_blk(16'h0006, 32'h1000, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("v4_hold_valid", 32'(xfer_valid), 32'h1);
      check("v4_hold_reg", 32'(reg_address), 32'h1);
      check("v4_hold_addr", mem_addr, 32'h1004);
      if (k < 3) begin
        start = (k == 1);
        reg_list = 16'hFFFF;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    xfer_ready = 1'b1;
    wait_idle(3, "v4_cycles");

    // V5: reset after the fifth accept aborts with no done
    for (int i = 0; i < 5; i++) push_x(4'(i), 32'(4 * i), 1'b0);
    start_blk(16'hFFFF, 32'h0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_all_zero("v5_abort");
    check("v5_queue", 32'(xq.size()), 32'h0);
    repeat (2) @(posedge clk); #1;
    check("v5_hold_idle", 32'(busy), 32'h0);
    reset = 1'b0;
    push_x(4'd0, 32'h40, 1'b0);
    push_x(4'd1, 32'h44, 1'b1);
    push_d(32'h48, 5'd2);
    start_blk(16'h0003, 32'h40, 1'b1, 1'b0);
    check("v5_restart_reg", 32'(reg_address), 32'h0);
    wait_idle(3, "v5_cycles");

    // V6: full list with address wrap past zero
    for (int i = 0; i < 16; i++) push_x(4'(i), 32'hFFFF_FFF8 + 32'(4 * i), (i == 15));
    push_d(32'h38, 5'd16);
    start_blk(16'hFFFF, 32'hFFFF_FFF8, 1'b1, 1'b0);
    wait_idle(17, "v6_cycles");
    check("v6_count", 32'(reg_count), 32'd16);

    @(posedge clk); #1;
    check("end_xfer_queue", 32'(xq.size()), 32'h0);
    check("end_done_queue", 32'(dq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
